// File: rtl/xor_share_arbiter_pkg.sv
// Shared types and helpers for the XOR-share arbiter slice.
//   rsp_state_e : occupancy of the single-entry response register
//   rr_next     : round-robin pointer advance, wrapping at n
package xor_share_arbiter_pkg;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 == n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/xor_share_arbiter_rr_pick.sv
// Round-robin priority picker, reusable by any shared-resource controller.
// Scans req_i starting at ptr_i and wrapping; the first set bit wins.
//   req_i : N-wide request vector
//   ptr_i : index with highest priority this cycle
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : binary index of the winner (zero when no request)
//   any_o : at least one request present
module xor_share_arbiter_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/xor_share_arbiter.sv
// Shares one registered bitwise XOR unit between NUM_REQ requesters with
// round-robin arbitration and a single-entry, back-pressured response register.
//   CLK, RST   : clock, asynchronous active-high reset
//   REQ_VALID  : per-requester operand valid
//   REQ_A/B    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   REQ_READY  : one-hot (or zero) accept
//   RSP_VALID  : result valid
//   RSP_DATA   : A ^ B of the accepted request
//   RSP_ID     : index of the requester that produced RSP_DATA
//   RSP_READY  : downstream accepts the result
//   GRANT_CNT  : accepted requests since reset, wrapping
module xor_share_arbiter
  import xor_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_A,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_B,
  output logic [NUM_REQ-1:0]       REQ_READY,
  output logic                     RSP_VALID,
  output logic [WIDTH-1:0]         RSP_DATA,
  output logic [ID_W-1:0]          RSP_ID,
  input  logic                     RSP_READY,
  output logic [CNT_W-1:0]         GRANT_CNT
);

  rsp_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic               out_free;
  logic               accept;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = REQ_A[g*WIDTH +: WIDTH];
    assign b_arr[g] = REQ_B[g*WIDTH +: WIDTH];
  end

  xor_share_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Gating on RST keeps REQ_READY low for the whole reset pulse, even though
  // the emptied response register would otherwise report out_free.
  assign out_free  = (state_q == RSP_EMPTY) || RSP_READY;
  assign accept    = win_any && out_free && !RST;
  assign REQ_READY = accept ? gnt : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = RSP_FULL;
      data_d  = a_arr[win_idx] ^ b_arr[win_idx];
      id_d    = win_idx;
      ptr_d   = ID_W'(rr_next(32'(win_idx), NUM_REQ));
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (RSP_READY) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RSP_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RSP_VALID = (state_q == RSP_FULL);
  assign RSP_DATA  = data_q;
  assign RSP_ID    = id_q;
  assign GRANT_CNT = cnt_q;

endmodule
